// File: rtl/fetch_fifo_feeder.sv
// Producer side of the fetch FIFO: issues sequential instruction fetches over a
// req/gnt/rvalid port and pushes {addr, rdata} into the fetch FIFO, with
// flush/redirect handled by draining in-flight responses before refetching.
module fetch_fifo_feeder #(
  parameter int unsigned NR_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] boot_addr_i,
  input  logic        flush_i,
  input  logic [63:0] flush_addr_i,
  output logic        instr_req_o,
  output logic [63:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        in_valid_o,
  output logic [63:0] in_addr_o,
  output logic [31:0] in_rdata_o,
  input  logic        in_ready_i
);

  localparam int unsigned DEPTH = NR_OUTSTANDING;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [63:0]        r_pc;
  logic [63:0]        w_pc_nxt;
  logic               r_req;
  logic               w_req_nxt;
  logic [63:0]        r_addr;
  logic [63:0]        w_addr_nxt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [CNT_W-1:0]   w_out_nxt;

  // In-order queue of granted addresses, popped by each response
  logic [63:0]        r_aq_addr [DEPTH];
  logic [PTR_W-1:0]   r_aq_wr;
  logic [PTR_W-1:0]   r_aq_rd;

  // Response buffer feeding the fetch FIFO
  logic [63:0]        r_buf_addr [DEPTH];
  logic [31:0]        r_buf_data [DEPTH];
  logic [PTR_W-1:0]   r_buf_wr;
  logic [PTR_W-1:0]   r_buf_rd;
  logic [PTR_W-1:0]   w_buf_rd_nxt;
  logic [CNT_W-1:0]   r_buf_cnt;
  logic [CNT_W-1:0]   w_buf_cnt_nxt;
  logic [CNT_W-1:0]   w_buf_after_pop;

  logic               r_in_valid;
  logic               w_in_valid_nxt;
  logic [63:0]        r_in_addr;
  logic [63:0]        w_in_addr_nxt;
  logic [31:0]        r_in_rdata;
  logic [31:0]        w_in_rdata_nxt;

  logic               w_gnt;
  logic               w_rsp;
  logic               w_push;
  logic               w_pop;
  logic [63:0]        w_rsp_addr;
  logic [SUM_W-1:0]   w_credit_sum;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = '0;
    else                        ptr_inc = p + PTR_W'(1);
  endfunction

  assign w_gnt      = r_req & instr_gnt_i;
  // A response with nothing outstanding is ignored so the counter cannot wrap
  assign w_rsp      = instr_rvalid_i & (r_out_cnt != '0);
  assign w_push     = w_rsp & (r_state == ST_FETCH) & ~flush_i;
  assign w_pop      = r_in_valid & in_ready_i & ~flush_i;
  assign w_rsp_addr = r_aq_addr[r_aq_rd];

  // Next state, next pc, request and output-stage computation
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_nxt       = r_req;
    w_addr_nxt      = r_addr;
    w_in_valid_nxt  = r_in_valid;
    w_in_addr_nxt   = r_in_addr;
    w_in_rdata_nxt  = r_in_rdata;

    w_out_nxt       = r_out_cnt + CNT_W'(w_gnt) - CNT_W'(w_rsp);
    w_buf_after_pop = r_buf_cnt - CNT_W'(w_pop);
    w_buf_cnt_nxt   = flush_i ? '0 : (w_buf_after_pop + CNT_W'(w_push));
    w_buf_rd_nxt    = w_pop ? ptr_inc(r_buf_rd) : r_buf_rd;
    w_credit_sum    = SUM_W'(w_out_nxt) + SUM_W'(w_buf_cnt_nxt);

    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
        w_pc_nxt    = boot_addr_i;
      end
      ST_FETCH: begin
        if (w_gnt) w_pc_nxt = r_pc + 64'd4;
      end
      ST_DRAIN: begin
        if ((r_out_cnt == '0) && !r_req) w_state_nxt = ST_FETCH;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase

    // Redirect wins over everything else
    if (flush_i) begin
      w_state_nxt = ST_DRAIN;
      w_pc_nxt    = flush_addr_i;
    end

    // A raised request is held with its address until granted
    if (r_req && !instr_gnt_i) begin
      w_req_nxt  = 1'b1;
      w_addr_nxt = r_addr;
    end else if ((w_state_nxt == ST_FETCH) && (w_credit_sum < SUM_W'(DEPTH))) begin
      w_req_nxt  = 1'b1;
      w_addr_nxt = w_pc_nxt;
    end else begin
      w_req_nxt  = 1'b0;
    end

    // Registered buffer head: bypass the incoming word when the buffer would be empty
    if (flush_i) begin
      w_in_valid_nxt = 1'b0;
    end else begin
      w_in_valid_nxt = (w_buf_cnt_nxt != '0);
      if (w_buf_after_pop == '0) begin
        if (w_push) begin
          w_in_addr_nxt  = w_rsp_addr;
          w_in_rdata_nxt = instr_rdata_i;
        end
      end else begin
        w_in_addr_nxt  = r_buf_addr[w_buf_rd_nxt];
        w_in_rdata_nxt = r_buf_data[w_buf_rd_nxt];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_BOOT;
    else       r_state <= w_state_nxt;
  end

  // Request port, counters and output stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_out_cnt  <= '0;
      r_in_valid <= 1'b0;
      r_in_addr  <= '0;
      r_in_rdata <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_out_cnt  <= w_out_nxt;
      r_in_valid <= w_in_valid_nxt;
      r_in_addr  <= w_in_addr_nxt;
      r_in_rdata <= w_in_rdata_nxt;
    end
  end

  // Granted-address queue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_aq_addr[i] <= '0;
      r_aq_wr <= '0;
      r_aq_rd <= '0;
    end else begin
      if (w_gnt) begin
        r_aq_addr[r_aq_wr] <= r_addr;
        r_aq_wr            <= ptr_inc(r_aq_wr);
      end
      if (w_rsp) r_aq_rd <= ptr_inc(r_aq_rd);
    end
  end

  // Response buffer; a flush empties it at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_buf_addr[i] <= '0;
        r_buf_data[i] <= '0;
      end
      r_buf_wr  <= '0;
      r_buf_rd  <= '0;
      r_buf_cnt <= '0;
    end else if (flush_i) begin
      r_buf_wr  <= '0;
      r_buf_rd  <= '0;
      r_buf_cnt <= '0;
    end else begin
      if (w_push) begin
        r_buf_addr[r_buf_wr] <= w_rsp_addr;
        r_buf_data[r_buf_wr] <= instr_rdata_i;
        r_buf_wr             <= ptr_inc(r_buf_wr);
      end
      r_buf_rd  <= w_buf_rd_nxt;
      r_buf_cnt <= w_buf_cnt_nxt;
    end
  end

  // A response that matches no request indicates a protocol error upstream
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(instr_rvalid_i && (r_out_cnt == '0)))
    else $error("fetch_fifo_feeder: rvalid with no outstanding request");

  assign instr_req_o  = r_req;
  assign instr_addr_o = r_addr;
  assign in_valid_o   = r_in_valid;
  assign in_addr_o    = r_in_addr;
  assign in_rdata_o   = r_in_rdata;

endmodule

// File: tb/tb_fetch_fifo_feeder.sv
// Directed bench for fetch_fifo_feeder: a small memory responder plus
// hand-computed expectations for boot, backpressure, grant delay, flush and reset.
module tb_fetch_fifo_feeder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] boot_addr_i = 64'h8000_0000;
  logic        flush_i = 1'b0;
  logic [63:0] flush_addr_i = '0;
  logic        instr_req_o;
  logic [63:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        in_valid_o;
  logic [63:0] in_addr_o;
  logic [31:0] in_rdata_o;
  logic        in_ready_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder knobs and logs
  int          gnt_delay = 0;
  int          wait_cnt  = 0;
  bit          rsp_en    = 1'b0;
  logic [63:0] q[$];
  logic [63:0] gnt_log[$];
  logic [63:0] got_addr[$];
  logic [31:0] got_data[$];

  fetch_fifo_feeder #(.NR_OUTSTANDING(2)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .boot_addr_i    (boot_addr_i),
    .flush_i        (flush_i),
    .flush_addr_i   (flush_addr_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .in_valid_o     (in_valid_o),
    .in_addr_o      (in_addr_o),
    .in_rdata_o     (in_rdata_o),
    .in_ready_i     (in_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: log transfers at the edge, then drive gnt/rvalid for the next cycle
  always @(posedge clk_i) begin
    logic [63:0] hd;
    if (rst_i) begin
      q.delete();
      gnt_log.delete();
      got_addr.delete();
      got_data.delete();
    end else begin
      if (instr_rvalid_i && (q.size() > 0)) void'(q.pop_front());
      if (instr_req_o && instr_gnt_i) begin
        q.push_back(instr_addr_o);
        gnt_log.push_back(instr_addr_o);
      end
      if (in_valid_o && in_ready_i) begin
        got_addr.push_back(in_addr_o);
        got_data.push_back(in_rdata_o);
      end
    end
    #1;
    if (rst_i) begin
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      wait_cnt       = 0;
    end else begin
      if (instr_req_o) begin
        if (wait_cnt >= gnt_delay) begin
          instr_gnt_i = 1'b1;
          wait_cnt    = 0;
        end else begin
          instr_gnt_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        instr_gnt_i = 1'b0;
        wait_cnt    = 0;
      end
      instr_rvalid_i = rsp_en && (q.size() > 0);
      if (instr_rvalid_i) begin
        hd            = q[0];
        instr_rdata_i = hd[31:0] ^ 32'h5A5A_0000;
      end else begin
        instr_rdata_i = '0;
      end
    end
  end

  task automatic do_reset(input logic [63:0] boot);
    @(negedge clk_i);
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    boot_addr_i = boot;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!instr_req_o && (n < budget)) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  initial begin
    logic [63:0] e_addr [3];
    logic [31:0] e_data [3];
    int n;

    // Reset values
    repeat (2) @(negedge clk_i);
    check("rst_req",    64'(instr_req_o), 64'd0);
    check("rst_addr",   instr_addr_o,     64'd0);
    check("rst_valid",  64'(in_valid_o),  64'd0);
    check("rst_inaddr", in_addr_o,        64'd0);
    check("rst_rdata",  64'(in_rdata_o),  64'd0);

    // 1: streaming fetch from boot address
    e_addr = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
    e_data = '{32'hDA5A_0000, 32'hDA5A_0004, 32'hDA5A_0008};
    gnt_delay = 0; rsp_en = 1'b1; in_ready_i = 1'b1;
    do_reset(64'h8000_0000);
    repeat (20) @(negedge clk_i);
    check("t1_count", 64'(got_addr.size() >= 3), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (got_addr.size() > i) begin
        check($sformatf("t1_addr%0d", i), got_addr[i], e_addr[i]);
        check($sformatf("t1_data%0d", i), 64'(got_data[i]), 64'(e_data[i]));
      end
    end

    // 2: backpressure from the start limits grants to the credit count
    in_ready_i = 1'b0;
    do_reset(64'h8000_0000);
    repeat (10) @(negedge clk_i);
    check("t2_grants",  64'(gnt_log.size()), 64'd2);
    check("t2_req_off", 64'(instr_req_o),    64'd0);
    check("t2_valid",   64'(in_valid_o),     64'd1);
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_addr",  in_addr_o,        64'h8000_0000);
      check("t2_hold_rdata", 64'(in_rdata_o),  64'hDA5A_0000);
      @(negedge clk_i);
    end
    in_ready_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check("t2_pushed", 64'(got_addr.size() >= 2), 64'd1);
    if (got_addr.size() >= 2) begin
      check("t2_push0", got_addr[0], 64'h8000_0000);
      check("t2_push1", got_addr[1], 64'h8000_0004);
    end
    check("t2_resume_n", 64'(gnt_log.size() >= 3), 64'd1);
    if (gnt_log.size() >= 3) check("t2_resume_addr", gnt_log[2], 64'h8000_0008);

    // 3: request and address held while grant is delayed
    gnt_delay = 3; in_ready_i = 1'b1;
    do_reset(64'h8000_0000);
    wait_req(10);
    check("t3_req_seen", 64'(instr_req_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_req_c%0d", i),  64'(instr_req_o), 64'd1);
      check($sformatf("t3_addr_c%0d", i), instr_addr_o,     64'h8000_0000);
      @(negedge clk_i);
    end
    check("t3_no_gnt_yet", 64'(gnt_log.size()), 64'd0);
    repeat (2) @(negedge clk_i);
    check("t3_gnt_addr", (gnt_log.size() > 0) ? gnt_log[0] : 64'hDEAD, 64'h8000_0000);
    gnt_delay = 0;

    // 4: flush with two requests in flight
    rsp_en = 1'b0; in_ready_i = 1'b1;
    do_reset(64'h8000_0000);
    repeat (5) @(negedge clk_i);
    check("t4_inflight", 64'(q.size()), 64'd2);
    flush_i = 1'b1; flush_addr_i = 64'h1000;
    @(negedge clk_i);
    flush_i = 1'b0; flush_addr_i = 64'h0;
    check("t4_valid_off", 64'(in_valid_o),  64'd0);
    check("t4_drain_req", 64'(instr_req_o), 64'd0);
    rsp_en = 1'b1;
    n = 0;
    while (!instr_req_o && (n < 20)) begin
      @(negedge clk_i);
      n++;
    end
    check("t4_req_seen",  64'(instr_req_o), 64'd1);
    check("t4_addr",      instr_addr_o,     64'h1000);
    check("t4_after_rsp", 64'(q.size()),    64'd0);
    check("t4_no_push",   64'(got_addr.size()), 64'd0);
    repeat (6) @(negedge clk_i);
    if (got_addr.size() > 0) begin
      check("t4_first_addr", got_addr[0],       64'h1000);
      check("t4_first_data", 64'(got_data[0]),  64'h5A5A_1000);
    end else begin
      check("t4_first_push", 64'(got_addr.size()), 64'd1);
    end

    // 5: flush in the cycle that has both a grant and a response
    rsp_en = 1'b1; in_ready_i = 1'b1;
    do_reset(64'h8000_0000);
    n = 0;
    while (!(instr_req_o && instr_gnt_i && instr_rvalid_i) && (n < 20)) begin
      @(negedge clk_i);
      n++;
    end
    check("t5_window", 64'(instr_req_o && instr_gnt_i && instr_rvalid_i), 64'd1);
    flush_i = 1'b1; flush_addr_i = 64'h2000;
    @(negedge clk_i);
    flush_i = 1'b0; flush_addr_i = 64'h0;
    check("t5_valid_off", 64'(in_valid_o), 64'd0);
    repeat (12) @(negedge clk_i);
    check("t5_grants", 64'(gnt_log.size() >= 3), 64'd1);
    if (gnt_log.size() >= 3) begin
      check("t5_disc1",   gnt_log[1], 64'h8000_0004);
      check("t5_restart", gnt_log[2], 64'h2000);
    end
    if (got_addr.size() > 0) begin
      check("t5_first_addr", got_addr[0],      64'h2000);
      check("t5_first_data", 64'(got_data[0]), 64'h5A5A_2000);
    end else begin
      check("t5_first_push", 64'(got_addr.size()), 64'd1);
    end

    // 6: reset in the middle of a stream with the buffer full
    in_ready_i = 1'b0;
    do_reset(64'h8000_0000);
    repeat (8) @(negedge clk_i);
    check("t6_full", 64'(in_valid_o), 64'd1);
    rst_i = 1'b1;
    boot_addr_i = 64'h4000_0000;
    #1;
    check("t6_req",    64'(instr_req_o), 64'd0);
    check("t6_addr",   instr_addr_o,     64'd0);
    check("t6_valid",  64'(in_valid_o),  64'd0);
    check("t6_inaddr", in_addr_o,        64'd0);
    check("t6_rdata",  64'(in_rdata_o),  64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    in_ready_i = 1'b1;
    wait_req(10);
    check("t6_req_seen", 64'(instr_req_o), 64'd1);
    check("t6_boot",     instr_addr_o,     64'h4000_0000);
    repeat (4) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
